// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between
// N_REQ byte producers. Each grant issues a one-cycle load strobe, then blocks
// further loads for FRAME_CLKS cycles because the transmitter has no busy flag.
// Optional feature macro: UART_SCHED_TAG_EN -- each grant first sends a tag
// byte {4'hA, source id}, then the data byte one frame window later.
module uart_tx_sched #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned FRAME_CLKS = 1760
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [8*N_REQ-1:0]         req_data_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_rdy_o,
  output logic                       busy_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned TW = $clog2(FRAME_CLKS);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(FRAME_CLKS - 1);
  localparam logic [IW-1:0] LAST_RST     = IW'(N_REQ - 1);

`ifdef UART_SCHED_TAG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_TAG2 = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             tx_rdy_q, tx_rdy_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
`ifdef UART_SCHED_TAG_EN
  logic [7:0]       hold_q, hold_d;
`endif

  logic             win_found;
  logic [IW-1:0]    win_id;
  logic [7:0]       win_data;
  logic             arb_window;

  // Round-robin pick: first active request scanning upward from last_q+1.
  always_comb begin
    win_found = 1'b0;
    win_id    = last_q;
    win_data  = 8'h00;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        if (!win_found && req_i[j] && (j == ((32'(last_q) + k) % N_REQ))) begin
          win_found = 1'b1;
          win_id    = IW'(j);
          win_data  = req_data_i[8*j +: 8];
        end
      end
    end
  end

  // State, frame timer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_WAIT;
      timer_q   <= TIMER_RELOAD;
      last_q    <= LAST_RST;
      grant_q   <= '0;
      ack_q     <= '0;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b1;
`ifdef UART_SCHED_TAG_EN
      hold_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_rdy_q  <= tx_rdy_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
`ifdef UART_SCHED_TAG_EN
      hold_q    <= hold_d;
`endif
    end
  end

  // Next-state: arbitrate when idle or at window expiry, otherwise count down.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_d    = last_q;
    grant_d   = grant_q;
    ack_d     = '0;
    tx_rdy_d  = 1'b0;
    tx_data_d = tx_data_q;
`ifdef UART_SCHED_TAG_EN
    hold_d    = hold_q;
`endif
    arb_window = (state_q == S_IDLE) || ((state_q == S_WAIT) && (timer_q == '0));

    if ((state_q != S_IDLE) && (timer_q != '0)) begin
      timer_d = timer_q - TW'(1);
    end

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (arb_window) begin
          if (win_found) begin
            ack_d[win_id] = 1'b1;
            tx_rdy_d      = 1'b1;
            grant_d       = win_id;
            last_d        = win_id;
            timer_d       = TIMER_RELOAD;
`ifdef UART_SCHED_TAG_EN
            hold_d        = win_data;
            tx_data_d     = {4'hA, 4'(win_id)};
            state_d       = S_TAG2;
`else
            tx_data_d     = win_data;
            state_d       = S_WAIT;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef UART_SCHED_TAG_EN
      // Second frame of a grant carries the held data byte; no ACK here.
      S_TAG2: begin
        if (timer_q == '0) begin
          tx_rdy_d  = 1'b1;
          tx_data_d = hold_q;
          timer_d   = TIMER_RELOAD;
          state_d   = S_WAIT;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign ack_o      = ack_q;
  assign tx_rdy_o   = tx_rdy_q;
  assign tx_data_o  = tx_data_q;
  assign busy_o     = busy_q;
  assign grant_id_o = grant_q;

endmodule
